inc16: RTL and testbench

//   Registered 16-bit incrementer: computes A + 1 with carry-out and presents the

---
 rtl/inc16.sv | 60 ++++++
 tb/tb_inc16.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/inc16.sv
// rtl/inc16.sv - registered WIDTH-bit incrementer with grouped carry lookahead
module inc16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             valid_out
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] sum_comb;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;
  logic             cout_comb;

  // Carry chain for A+1.
  // Each 4-bit group skips its ripple when all its bits are one, by passing the carry straight to the next group.
  always_comb begin
    c        = '0;
    sum_comb = '0;
    gp       = '0;
    gc       = '0;
    gc[0]    = 1'b1;
    for (int g = 0; g < NG; g++) begin
      gp[g]     = &A[4*g +: 4];
      gc[g+1]   = gc[g] & gp[g];
      c[4*g]    = gc[g];
      for (int b = 0; b < 3; b++) begin
        c[4*g+b+1] = A[4*g+b] & c[4*g+b];
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      sum_comb[i] = A[i] ^ c[i];
    end
  end

  assign cout_comb = gc[NG];

  // Output register: capture on en, otherwise hold the result and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      valid_out <= 1'b0;
    end else if (en) begin
      Sum       <= sum_comb;
      Cout      <= cout_comb;
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inc16.sv
// tb/tb_inc16.sv - randomized and directed self-checking bench for inc16
module tb_inc16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] A;
  logic [15:0] Sum;
  logic        Cout;
  logic        valid_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [16:0] exp_res;
  logic [17:0] got;
  logic [17:0] want;

  inc16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .A         (A),
    .Sum       (Sum),
    .Cout      (Cout),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 17-bit arithmetic, carry is bit 16.
  function automatic logic [16:0] ref_inc(input logic [15:0] a);
    return {1'b0, a} + 17'd1;
  endfunction

  // Drive one capture at the falling edge and sample just after the rising edge.
  task automatic capture(input logic [15:0] a);
    @(negedge clk);
    A  = a;
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en    = 1'b0;
    A     = 16'h1234;
    #2;
    total_cnt++;
    got  = {Cout, Sum, valid_out};
    want = 18'd0;
    if (got !== want)
      $display("FAIL reset_no_clk: got cout/sum/valid=%h want %h", got, want);
    else
      pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    got = {Cout, Sum, valid_out};
    if (got !== want)
      $display("FAIL reset_release_idle: got %h want %h", got, want);
    else
      pass_cnt++;
  endtask

  task automatic test_directed;
    logic [15:0] vec [0:6];
    vec[0] = 16'h0001; vec[1] = 16'hFFFF; vec[2] = 16'hAAAA; vec[3] = 16'h0000;
    vec[4] = 16'h0FFF; vec[5] = 16'h00FF; vec[6] = 16'hFFFE;
    for (int k = 0; k < 7; k++) begin
      capture(vec[k]);
      exp_res = ref_inc(vec[k]);
      total_cnt++;
      got  = {Cout, Sum, valid_out};
      want = {exp_res, 1'b1};
      if (got !== want)
        $display("FAIL directed A=%h: got cout/sum/valid=%h want %h", vec[k], got, want);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_hold;
    logic [15:0] a0;
    a0 = 16'h7FFF;
    capture(a0);
    exp_res = ref_inc(a0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      en = 1'b0;
      A  = 16'($urandom);
      @(posedge clk);
      #1;
      total_cnt++;
      got  = {Cout, Sum, valid_out};
      want = {exp_res, 1'b0};
      if (got !== want)
        $display("FAIL hold cycle %0d: got %h want %h", k, got, want);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_async_reset;
    capture(16'hFFFF);
    @(negedge clk);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    got  = {Cout, Sum, valid_out};
    want = 18'd0;
    if (got !== want)
      $display("FAIL async_reset_mid: got %h want %h", got, want);
    else
      pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    capture(16'h0003);
    exp_res = ref_inc(16'h0003);
    total_cnt++;
    got  = {Cout, Sum, valid_out};
    want = {exp_res, 1'b1};
    if (got !== want)
      $display("FAIL first_capture_after_reset: got %h want %h", got, want);
    else
      pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] a;
    logic        e;
    logic [16:0] held;
    held = ref_inc(16'h0003);
    for (int k = 0; k < 400; k++) begin
      a = 16'($urandom);
      if (k % 37 == 0) a = 16'hFFFF;
      e = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      A  = a;
      en = e;
      @(posedge clk);
      #1;
      if (e) held = ref_inc(a);
      total_cnt++;
      got  = {Cout, Sum, valid_out};
      want = {held, e};
      if (got !== want)
        $display("FAIL back_to_back k=%0d A=%h en=%b: got %h want %h", k, a, e, got, want);
      else
        pass_cnt++;
    end
  endtask

  task automatic test_sweep;
    logic [15:0] a;
    for (int k = 0; k < 65536; k++) begin
      a = 16'(k);
      capture(a);
      exp_res = ref_inc(a);
      total_cnt++;
      got  = {Cout, Sum, valid_out};
      want = {exp_res, 1'b1};
      if (got !== want)
        $display("FAIL sweep A=%h: got %h want %h", a, got, want);
      else
        pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
